// File: rtl/arith_pipe_pkg.sv
// Shared definitions for the parametrised four-operand arithmetic pipeline:
// operation modes and the output-width rule.
package arith_pipe_pkg;

    typedef enum logic [1:0] {
        MODE_SUMPROD = 2'b00,
        MODE_DOT     = 2'b01,
        MODE_ACC     = 2'b10
    } mode_e;

    // Product of two (W+1)-bit sums needs 2W+2 bits; G guard bits extend the accumulator.
    function automatic int unsigned ow_width(input int unsigned w, input int unsigned g);
        return 2 * w + 2 + g;
    endfunction

endpackage

// File: rtl/arith_pipe_stage.sv
// One pipeline stage: valid bit plus payload register, advanced by a shared
// enable and cleared asynchronously.
module arith_pipe_stage #(
    parameter int unsigned PW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          i_valid,
    input  logic [PW-1:0] i_data,
    output logic          o_valid,
    output logic [PW-1:0] o_data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else if (en) begin
            o_valid <= i_valid;
            // Bubbles leave the payload untouched to avoid needless toggling.
            if (i_valid) begin
                o_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/arith_pipe_param.sv
// Three-stage four-operand arithmetic pipeline (sum-product, dot-product or
// running accumulation) with valid/ready flow control on both sides.
module arith_pipe_param
    import arith_pipe_pkg::*;
#(
    parameter  int unsigned W  = 32,
    parameter  int unsigned G  = 8,
    localparam int unsigned OW = ow_width(W, G)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    mode,
    input  logic          acc_clr,
    input  logic [W-1:0]  in1,
    input  logic [W-1:0]  in2,
    input  logic [W-1:0]  in3,
    input  logic [W-1:0]  in4,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data
);

    localparam int unsigned PROD_W = 2 * W + 2;

    typedef struct packed {
        logic [1:0] mode;
        logic       clr;
        logic [W:0] a;
        logic [W:0] b;
        logic [W:0] c;
        logic [W:0] d;
    } s1_t;

    typedef struct packed {
        logic [1:0]        mode;
        logic              clr;
        logic [PROD_W-1:0] p;
    } s2_t;

    logic          w_en;
    s1_t           w_s1_d;
    s1_t           r_s1;
    logic          r_s1_valid;
    s2_t           w_s2_d;
    s2_t           r_s2;
    logic          r_s2_valid;
    logic [OW-1:0] w_p_ext;
    logic [OW-1:0] w_acc_sum;
    logic          r_out_valid;
    logic [OW-1:0] r_out_data;
    logic [OW-1:0] r_acc;

    // The whole pipe advances together whenever the output slot is free or being drained.
    assign w_en      = !r_out_valid | out_ready;
    assign in_ready  = w_en;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;

    always_comb begin
        w_s1_d      = '0;
        w_s1_d.mode = mode;
        w_s1_d.clr  = acc_clr;
        if (mode == MODE_DOT) begin
            w_s1_d.a = {1'b0, in1};
            w_s1_d.b = {1'b0, in2};
            w_s1_d.c = {1'b0, in3};
            w_s1_d.d = {1'b0, in4};
        end else begin
            w_s1_d.a = {1'b0, in1} + {1'b0, in2};
            w_s1_d.b = {1'b0, in3} + {1'b0, in4};
        end
    end

    arith_pipe_stage #(.PW($bits(s1_t))) u_s1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (w_en),
        .i_valid (in_valid),
        .i_data  (w_s1_d),
        .o_valid (r_s1_valid),
        .o_data  (r_s1)
    );

    always_comb begin
        w_s2_d      = '0;
        w_s2_d.mode = r_s1.mode;
        w_s2_d.clr  = r_s1.clr;
        if (r_s1.mode == MODE_DOT) begin
            w_s2_d.p = PROD_W'(r_s1.a) * PROD_W'(r_s1.b)
                     + PROD_W'(r_s1.c) * PROD_W'(r_s1.d);
        end else begin
            w_s2_d.p = PROD_W'(r_s1.a) * PROD_W'(r_s1.b);
        end
    end

    arith_pipe_stage #(.PW($bits(s2_t))) u_s2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (w_en),
        .i_valid (r_s1_valid),
        .i_data  (w_s2_d),
        .o_valid (r_s2_valid),
        .o_data  (r_s2)
    );

    assign w_p_ext   = OW'(r_s2.p);
    assign w_acc_sum = r_acc + w_p_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_acc       <= '0;
        end else if (w_en) begin
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                if (r_s2.mode == MODE_ACC) begin
                    if (r_s2.clr) begin
                        r_acc      <= w_p_ext;
                        r_out_data <= w_p_ext;
                    end else begin
                        r_acc      <= w_acc_sum;
                        r_out_data <= w_acc_sum;
                    end
                end else begin
                    r_out_data <= w_p_ext;
                end
            end
        end
    end

endmodule

// File: tb/tb_arith_pipe_param.sv
// Directed bench for arith_pipe_param: a W=32 instance with an expected-value
// queue and output monitor, plus a W=4 G=0 instance for accumulator wrap.
module tb_arith_pipe_param;

    logic clk;
    logic rst_n;

    logic        a_in_valid, a_in_ready, a_acc_clr, a_out_valid, a_out_ready;
    logic [1:0]  a_mode;
    logic [31:0] a_in1, a_in2, a_in3, a_in4;
    logic [73:0] a_out_data;

    logic        b_in_valid, b_in_ready, b_acc_clr, b_out_valid, b_out_ready;
    logic [1:0]  b_mode;
    logic [3:0]  b_in1, b_in2, b_in3, b_in4;
    logic [9:0]  b_out_data;

    int n_total = 0;
    int n_bad   = 0;
    logic [127:0] exp_q[$];
    logic mon_en;

    arith_pipe_param #(.W(32), .G(8)) u_dut32 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .mode      (a_mode),
        .acc_clr   (a_acc_clr),
        .in1       (a_in1),
        .in2       (a_in2),
        .in3       (a_in3),
        .in4       (a_in4),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_data  (a_out_data)
    );

    arith_pipe_param #(.W(4), .G(0)) u_dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .mode      (b_mode),
        .acc_clr   (b_acc_clr),
        .in1       (b_in1),
        .in2       (b_in2),
        .in3       (b_in3),
        .in4       (b_in4),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_data  (b_out_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic put(input logic [1:0] m, input logic c,
                       input logic [31:0] x1, input logic [31:0] x2,
                       input logic [31:0] x3, input logic [31:0] x4,
                       input logic [127:0] e);
        int unsigned n;
        logic ok;
        n = 0;
        a_mode = m; a_acc_clr = c;
        a_in1 = x1; a_in2 = x2; a_in3 = x3; a_in4 = x4;
        a_in_valid = 1'b1;
        do begin
            #1;
            ok = a_in_ready;
            tick();
            n++;
        end while (!ok && n < 30);
        if (ok) exp_q.push_back(e);
        else    check("accept_timeout", 128'(ok), 128'd1);
    endtask

    task automatic drain();
        int unsigned n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        check("drain", 128'(exp_q.size()), 128'd0);
    endtask

    // Output monitor: samples mid-cycle so out_ready reflects the upcoming edge.
    initial begin
        logic         prev_stall;
        logic [73:0]  prev_data;
        logic [127:0] e;
        prev_stall = 1'b0;
        prev_data  = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n || !mon_en) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", 128'(a_out_valid), 128'd1);
                    check("hold_data", 128'(a_out_data), 128'(prev_data));
                end
                if (a_out_valid && a_out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_output", 128'd1, 128'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("result", 128'(a_out_data), e);
                    end
                end
                prev_stall = a_out_valid && !a_out_ready;
                prev_data  = a_out_data;
            end
        end
    end

    initial begin
        rst_n = 1'b0; mon_en = 1'b0;
        a_in_valid = 1'b0; a_mode = 2'b00; a_acc_clr = 1'b0; a_out_ready = 1'b1;
        a_in1 = 32'd2; a_in2 = 32'd2; a_in3 = 32'd2; a_in4 = 32'd2;
        b_in_valid = 1'b0; b_mode = 2'b00; b_acc_clr = 1'b0; b_out_ready = 1'b1;
        b_in1 = '0; b_in2 = '0; b_in3 = '0; b_in4 = '0;

        // Reset held with a valid beat presented; then 3-cycle latency of 2+2 * 2+2.
        a_in_valid = 1'b1;
        repeat (3) begin
            tick();
            check("rst_out_valid", 128'(a_out_valid), 128'd0);
            check("rst_out_data", 128'(a_out_data), 128'd0);
        end
        rst_n = 1'b1;
        #1;
        check("rel_in_ready", 128'(a_in_ready), 128'd1);
        tick();
        a_in_valid = 1'b0;
        check("lat1_valid", 128'(a_out_valid), 128'd0);
        tick();
        check("lat2_valid", 128'(a_out_valid), 128'd0);
        tick();
        check("lat3_valid", 128'(a_out_valid), 128'd1);
        check("lat3_data", 128'(a_out_data), 128'd16);
        tick();
        check("lat4_valid", 128'(a_out_valid), 128'd0);
        mon_en = 1'b1;

        // Dot product back-to-back with sum-product.
        put(2'b01, 1'b0, 32'd3, 32'd4, 32'd5, 32'd6, 128'd42);
        put(2'b00, 1'b0, 32'd1, 32'd1, 32'd1, 32'd1, 128'd4);
        a_in_valid = 1'b0;
        drain();

        // Accumulation interleaved with other modes and a bubble.
        put(2'b10, 1'b1, 32'd1, 32'd1, 32'd1, 32'd1, 128'd4);
        put(2'b00, 1'b0, 32'd2, 32'd2, 32'd2, 32'd2, 128'd16);
        put(2'b10, 1'b0, 32'd1, 32'd2, 32'd3, 32'd0, 128'd13);
        a_in_valid = 1'b0;
        tick();
        put(2'b11, 1'b1, 32'd1, 32'd2, 32'd3, 32'd4, 128'd21);
        put(2'b10, 1'b0, 32'd1, 32'd0, 32'd0, 32'd1, 128'd14);
        a_in_valid = 1'b0;
        drain();

        // Five-beat stream with a 4-cycle consumer stall in the middle.
        fork
            begin
                put(2'b00, 1'b0, 32'd1, 32'd2, 32'd3, 32'd4, 128'd21);
                put(2'b00, 1'b0, 32'd2, 32'd3, 32'd4, 32'd5, 128'd45);
                put(2'b00, 1'b0, 32'd10, 32'd0, 32'd0, 32'd1, 128'd10);
                put(2'b01, 1'b0, 32'd1, 32'd2, 32'd3, 32'd4, 128'd14);
                put(2'b00, 1'b0, 32'd7, 32'd0, 32'd8, 32'd1, 128'd63);
                a_in_valid = 1'b0;
            end
            begin
                repeat (4) tick();
                a_out_ready = 1'b0;
                repeat (4) begin
                    #1;
                    check("stall_in_ready", 128'(a_in_ready), 128'd0);
                    tick();
                end
                a_out_ready = 1'b1;
            end
        join
        drain();

        // Full-scale operands: (2^33-2)^2.
        put(2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
            128'h3_FFFF_FFF8_0000_0004);
        a_in_valid = 1'b0;
        drain();

        // W=4 G=0: 30*30 = 900, then 1800 mod 1024 = 776, then restart at 900.
        b_mode = 2'b10;
        b_in1 = 4'd15; b_in2 = 4'd15; b_in3 = 4'd15; b_in4 = 4'd15;
        b_in_valid = 1'b1; b_acc_clr = 1'b1;
        tick();
        b_acc_clr = 1'b0;
        tick();
        b_acc_clr = 1'b1;
        check("w4_lat_valid", 128'(b_out_valid), 128'd0);
        tick();
        b_in_valid = 1'b0;
        check("w4_b1_valid", 128'(b_out_valid), 128'd1);
        check("w4_b1_data", 128'(b_out_data), 128'd900);
        tick();
        check("w4_b2_data", 128'(b_out_data), 128'd776);
        tick();
        check("w4_b3_valid", 128'(b_out_valid), 128'd1);
        check("w4_b3_data", 128'(b_out_data), 128'd900);
        tick();
        check("w4_idle_valid", 128'(b_out_valid), 128'd0);

        // Reset with the pipe full of accumulate beats; acc must restart at zero.
        mon_en = 1'b0;
        a_mode = 2'b10; a_acc_clr = 1'b1;
        a_in1 = 32'd1; a_in2 = 32'd1; a_in3 = 32'd1; a_in4 = 32'd1;
        a_in_valid = 1'b1;
        tick();
        a_acc_clr = 1'b0;
        tick();
        tick();
        check("pre_rst_valid", 128'(a_out_valid), 128'd1);
        check("pre_rst_data", 128'(a_out_data), 128'd4);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 128'(a_out_valid), 128'd0);
        check("mid_rst_data", 128'(a_out_data), 128'd0);
        a_in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        tick();
        check("post_rst_valid", 128'(a_out_valid), 128'd0);
        mon_en = 1'b1;
        put(2'b10, 1'b0, 32'd1, 32'd1, 32'd1, 32'd1, 128'd4);
        a_in_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
